// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end: default address/instruction
// widths, the default reset fetch address, and the fetch FSM state encoding.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int unsigned             CPU_ADDR_W   = 16;
   localparam int unsigned             CPU_INSTR_W  = 32;
   localparam logic [CPU_ADDR_W-1:0]   CPU_RESET_PC = '0;

   // Fetch FSM: IDLE issues nothing, FETCH issues reads while there is room.
   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry synchronous FIFO holding {instruction, pc} pairs for the fetch
// stage. Head entry is presented from registered storage. Flush empties the
// queue in one cycle; simultaneous push+pop is legal when full.
//
// Ports:
//   clk          in   clock, all state updates on rising edge
//   i_reset      in   synchronous active-high reset
//   i_flush      in   discard all entries (wins over push)
//   i_push       in   write {i_push_instr, i_push_pc}
//   i_push_instr in   instruction word to write
//   i_push_pc    in   pc of the instruction to write
//   i_pop        in   remove the head entry (ignored when empty)
//   o_head_valid out  queue is non-empty
//   o_head_instr out  head instruction (0 when empty)
//   o_head_pc    out  head pc (0 when empty)
//   o_count      out  number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
   parameter  int unsigned DEPTH   = 2,
   parameter  int unsigned INSTR_W = 32,
   parameter  int unsigned ADDR_W  = 16,
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               i_reset,
   input  logic               i_flush,
   input  logic               i_push,
   input  logic [INSTR_W-1:0] i_push_instr,
   input  logic [ADDR_W-1:0]  i_push_pc,
   input  logic               i_pop,
   output logic               o_head_valid,
   output logic [INSTR_W-1:0] o_head_instr,
   output logic [ADDR_W-1:0]  o_head_pc,
   output logic [CNT_W-1:0]   o_count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } entry_t;

   entry_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_do_pop;
   logic w_do_push;

   assign w_do_pop  = i_pop && (r_count != '0);
   // A push into a full queue is accepted only if the head leaves this cycle.
   assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

   // NOTE: the storage array is deliberately not reset; validity is tracked by
   // r_count alone, so clearing data words would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) begin
         r_mem[r_wr_ptr] <= '{instr: i_push_instr, pc: i_push_pc};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (i_reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Head is forced to zero when empty so outputs never expose stale storage.
   assign o_head_valid = (r_count != '0);
   assign o_head_instr = o_head_valid ? r_mem[r_rd_ptr].instr : '0;
   assign o_head_pc    = o_head_valid ? r_mem[r_rd_ptr].pc    : '0;
   assign o_count      = r_count;

endmodule : fetch_fifo

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: issues word reads to synchronous program memory, tags returned
// words with their pc, buffers them in a prefetch queue and presents them to
// decode over valid/ready. A redirect flushes the queue and any in-flight read
// and restarts fetching at redirect_pc.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   run          in   fetch enable; 0 stops new requests
//   mem_addr     out  program memory word address (= fetch pc)
//   mem_re       out  read request, accepted at the edge where it is 1
//   mem_rdata    in   read data, valid the cycle after acceptance
//   instr        out  head instruction
//   instr_pc     out  pc of head instruction
//   instr_valid  out  head valid
//   instr_ready  in   decode accepts head when instr_valid & instr_ready
//   redirect     in   one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc  in   new fetch address
// -----------------------------------------------------------------------------
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned        ADDR_W   = CPU_ADDR_W,
   parameter int unsigned        INSTR_W  = CPU_INSTR_W,
   parameter int unsigned        DEPTH    = 2,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_re,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fetch_state_t       r_state;
   fetch_state_t       w_state_next;
   logic [ADDR_W-1:0]  r_fetch_pc;
   logic [ADDR_W-1:0]  r_req_pc;
   logic               r_inflight;

   logic               w_pop;
   logic               w_push;
   logic               w_space;
   logic [CNT_W-1:0]   w_count;
   logic [CNT_W:0]     w_occupancy;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   // NOTE: the default assignment first keeps every path assigned, so this
   // combinational block can never infer a latch.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (run)  w_state_next = FETCH;
         FETCH:   if (!run) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_re = (r_state == FETCH) && run && !redirect && w_space;
   end

   // ------------------------------------------------------- flow control
   assign w_pop = instr_valid && instr_ready;

   // Slots already committed (stored + returning) minus the one leaving now.
   // count + inflight >= pop always holds, so the subtraction cannot wrap.
   assign w_occupancy = (CNT_W+1)'(w_count) + (CNT_W+1)'(r_inflight)
                      - (CNT_W+1)'(w_pop);
   assign w_space     = (w_occupancy < (CNT_W+1)'(DEPTH));

   // Returning data is dropped if a redirect lands in its return cycle.
   assign w_push   = r_inflight && !redirect;
   assign mem_addr = r_fetch_pc;

   // ---------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= RESET_PC;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= mem_re;
         if (mem_re) r_req_pc <= r_fetch_pc;
         // Redirect wins even when stopped; pc wraps modulo 2^ADDR_W.
         if (redirect)    r_fetch_pc <= redirect_pc;
         else if (mem_re) r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .INSTR_W (INSTR_W),
      .ADDR_W  (ADDR_W)
   ) u_fifo (
      .clk          (clk),
      .i_reset      (reset),
      .i_flush      (redirect),
      .i_push       (w_push),
      .i_push_instr (mem_rdata),
      .i_push_pc    (r_req_pc),
      .i_pop        (w_pop),
      .o_head_valid (instr_valid),
      .o_head_instr (instr),
      .o_head_pc    (instr_pc),
      .o_count      (w_count)
   );

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench: a table of per-cycle inputs and hand-derived outputs, plus
// hand-written sequences for run-stop drain, idle hold and start-up latency.
// Program memory model returns 0x02000000 + address one cycle after a read.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic [15:0] mem_addr;
   logic        mem_re;
   logic [31:0] mem_rdata = '0;
   logic [31:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [15:0] redirect_pc;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .mem_addr    (mem_addr),
      .mem_re      (mem_re),
      .mem_rdata   (mem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return 32'h0200_0000 + {16'h0000, a};
   endfunction

   always @(posedge clk) begin
      if (mem_re) mem_rdata <= mem_word(mem_addr);
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          rst;
      bit          run;
      bit          rdy;
      bit          redir;
      logic [15:0] rpc;
      bit          e_re;
      logic [15:0] e_addr;
      bit          e_v;
      logic [15:0] e_pc;
   } vec_t;

   vec_t vecs[$];

   task automatic row(input bit rst, input bit rn, input bit rdy,
                      input bit redir, input logic [15:0] rpc,
                      input bit e_re, input logic [15:0] e_addr,
                      input bit e_v, input logic [15:0] e_pc);
      vec_t v;
      v.rst = rst; v.run = rn; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
      v.e_re = e_re; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc;
      vecs.push_back(v);
   endtask

   initial begin
      int bad;
      int lat;

      // Reset with run high: nothing fetched, outputs at reset values.
      repeat (3) row(1, 1, 1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000);
      // Cycle 0..2 after release: IDLE->FETCH, first request, in flight.
      row(0, 1, 1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0000, 0, 16'h0000);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0001, 0, 16'h0000);
      // Streaming, one instruction per cycle.
      row(0, 1, 1, 0, 16'h0, 1, 16'h0002, 1, 16'h0000);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0003, 1, 16'h0001);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0004, 1, 16'h0002);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0005, 1, 16'h0003);
      // Backpressure for 10 cycles: head frozen, requests stop.
      repeat (10) row(0, 1, 0, 0, 16'h0, 0, 16'h0006, 1, 16'h0004);
      // Release: no word lost or duplicated.
      row(0, 1, 1, 0, 16'h0, 1, 16'h0006, 1, 16'h0004);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0007, 1, 16'h0005);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0008, 1, 16'h0006);
      // Redirect to 0x0040 with a word in flight and the queue filling.
      row(0, 1, 0, 1, 16'h0040, 0, 16'h0009, 1, 16'h0007);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0040, 0, 16'h0000);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0041, 0, 16'h0000);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0042, 1, 16'h0040);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0043, 1, 16'h0041);
      // Redirect to 0xFFFE coinciding with a handshake, then pc wrap.
      row(0, 1, 1, 1, 16'hFFFE, 0, 16'h0044, 1, 16'h0042);
      row(0, 1, 1, 0, 16'h0, 1, 16'hFFFE, 0, 16'h0000);
      row(0, 1, 1, 0, 16'h0, 1, 16'hFFFF, 0, 16'h0000);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0000, 1, 16'hFFFE);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0001, 1, 16'hFFFF);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0002, 1, 16'h0000);
      // Queue filling, then reset mid-operation, then run held low.
      row(0, 1, 0, 0, 16'h0, 0, 16'h0003, 1, 16'h0001);
      row(1, 1, 0, 0, 16'h0, 0, 16'h0003, 1, 16'h0001);
      repeat (6) row(0, 0, 0, 0, 16'h0, 0, 16'h0000, 0, 16'h0000);
      // Restart from RESET_PC.
      row(0, 1, 1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0000, 0, 16'h0000);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0001, 0, 16'h0000);
      row(0, 1, 1, 0, 16'h0, 1, 16'h0002, 1, 16'h0000);

      reset = 1'b1; run = 1'b1; instr_ready = 1'b1;
      redirect = 1'b0; redirect_pc = '0;
      @(posedge clk);

      foreach (vecs[i]) begin
         #1;
         reset       = vecs[i].rst;
         run         = vecs[i].run;
         instr_ready = vecs[i].rdy;
         redirect    = vecs[i].redir;
         redirect_pc = vecs[i].rpc;
         #1;
         check($sformatf("row%0d mem_re", i), 32'(mem_re), 32'(vecs[i].e_re));
         check($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
         check($sformatf("row%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_v));
         if (vecs[i].e_v) begin
            check($sformatf("row%0d instr_pc", i), 32'(instr_pc), 32'(vecs[i].e_pc));
            check($sformatf("row%0d instr", i), instr, mem_word(vecs[i].e_pc));
         end else if (vecs[i].rst) begin
            check($sformatf("row%0d reset instr", i), instr, 32'h0);
            check($sformatf("row%0d reset instr_pc", i), 32'(instr_pc), 32'h0);
         end
         @(posedge clk);
      end
      redirect = 1'b0;

      // Run dropped mid-stream: in-flight word still lands, nothing new issued.
      #1; run = 1'b0; instr_ready = 1'b0; #1;
      check("stop mem_re", 32'(mem_re), 32'h0);
      check("stop head pc", 32'(instr_pc), 32'h0001);
      @(posedge clk);
      #1; instr_ready = 1'b1; #1;
      check("drain pc1", 32'(instr_pc), 32'h0001);
      check("drain mem_re", 32'(mem_re), 32'h0);
      @(posedge clk);
      #2;
      check("drain valid2", 32'(instr_valid), 32'h1);
      check("drain pc2", 32'(instr_pc), 32'h0002);
      @(posedge clk);
      #2;
      check("drain empty", 32'(instr_valid), 32'h0);

      // Reset, then run=0 must hold mem_re low indefinitely.
      #1; reset = 1'b1;
      @(posedge clk);
      #1; reset = 1'b0;
      bad = 0;
      repeat (30) begin
         #1;
         if (mem_re !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 16'h0) bad++;
         @(posedge clk);
      end
      check("idle hold bad cycles", 32'(bad), 32'h0);

      // Start-up latency from run asserted in IDLE: valid 3 cycles later.
      #1; run = 1'b1;
      lat = 0;
      #1;
      while (instr_valid !== 1'b1 && lat < 10) begin
         @(posedge clk);
         #2;
         lat++;
      end
      check("startup latency", 32'(lat), 32'd3);
      check("startup pc", 32'(instr_pc), 32'h0000);
      check("startup instr", instr, 32'h0200_0000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_instr_fetch_unit
